// File: rtl/fetch_arbiter_pkg.sv
// Shared definitions for the instruction-fetch arbiter: address/instruction
// widths, arbiter FSM encoding and the round-robin pick helper.
// Imported by fetch_req_slot and fetch_arbiter.
package fetch_arbiter_pkg;

  localparam int RW     = 16;   // fetch address width
  localparam int I_SIZE = 32;   // instruction word width

  // Arbiter FSM encoding, also reused by the data-port arbiter.
  typedef enum logic {
    FA_IDLE = 1'b0,
    FA_BUSY = 1'b1
  } fa_state_e;

  // Returns the index of the core to grant. Only meaningful when at least one
  // request is valid. On a tie the core that did not win last time is chosen.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_grant);
    if (req0 && req1) begin
      return ~last_grant;
    end
    return req1;
  endfunction

endpackage

// File: rtl/fetch_req_slot.sv
// Per-core fetch request slot: captures the address/attributes on submit and
// tracks pending plus stale state of that core's in-flight transaction.
// Ports: clk_i/rst_i; submit_i, active_i from the core; req addr/attributes in;
//        grant_i (arbiter consumes the request), inflight_i (this core owns the
//        bus); req_vld_o + addr/attribute outputs; stale_o for the in-flight txn.
module fetch_req_slot
  import fetch_arbiter_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          submit_i,
  input  logic          active_i,
  input  logic [RW-1:0] addr_i,
  input  logic [7:0]    addr_high_i,
  input  logic          page_i,
  input  logic          long_i,
  input  logic          grant_i,
  input  logic          inflight_i,
  output logic          req_vld_o,
  output logic [RW-1:0] addr_o,
  output logic [7:0]    addr_high_o,
  output logic          page_o,
  output logic          long_o,
  output logic          stale_o
);

  logic          pending_q, pending_d;
  logic          stale_q, stale_d;
  logic [RW-1:0] addr_q, addr_d;
  logic [7:0]    high_q, high_d;
  logic          page_q, page_d;
  logic          long_q, long_d;
  logic          load;
  logic          kill;

  // A fresh submit is visible to the arbiter in the same cycle so an idle bus
  // can be granted on the submit edge itself.
  assign load = submit_i & active_i;
  // Anything that supersedes the in-flight transaction: a new submit or the
  // core being disabled.
  assign kill = submit_i | ~active_i;

  always_comb begin
    pending_d = active_i & ~grant_i & (pending_q | load);
    stale_d   = stale_q;
    if (grant_i) begin
      stale_d = 1'b0;
    end else if (inflight_i && kill) begin
      stale_d = 1'b1;
    end
    addr_d = addr_q;
    high_d = high_q;
    page_d = page_q;
    long_d = long_q;
    if (load) begin
      addr_d = addr_i;
      high_d = addr_high_i;
      page_d = page_i;
      long_d = long_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      stale_q   <= 1'b0;
      addr_q    <= '0;
      high_q    <= '0;
      page_q    <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      stale_q   <= stale_d;
      addr_q    <= addr_d;
      high_q    <= high_d;
      page_q    <= page_d;
      long_q    <= long_d;
    end
  end

  assign req_vld_o   = active_i & (pending_q | submit_i);
  assign addr_o      = load ? addr_i      : addr_q;
  assign addr_high_o = load ? addr_high_i : high_q;
  assign page_o      = load ? page_i      : page_q;
  assign long_o      = load ? long_i      : long_q;
  // Includes same-cycle supersession so an ack arriving together with a new
  // submit (or a disable) is dropped.
  assign stale_o     = stale_q | (inflight_i & kill);

endmodule

// File: rtl/fetch_arbiter.sv
// Shares one instruction-memory port between two cores: round-robin grant,
// one outstanding transaction, response routing, stale drop and timeout abort.
// Ports: i_clk/i_rst; per core i_cN_req_* / i_cN_instr_* in and
//        o_cN_req_data(_valid)/o_cN_fetch_err out; o_mem_* request, i_mem_data/ack.
module fetch_arbiter
  import fetch_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [RW-1:0]     i_c0_req_addr,
  input  logic              i_c0_req_active,
  input  logic              i_c0_req_submit,
  input  logic              i_c0_instr_page,
  input  logic              i_c0_instr_long,
  input  logic [7:0]        i_c0_instr_addr_high,
  output logic [I_SIZE-1:0] o_c0_req_data,
  output logic              o_c0_req_data_valid,
  output logic              o_c0_fetch_err,
  input  logic [RW-1:0]     i_c1_req_addr,
  input  logic              i_c1_req_active,
  input  logic              i_c1_req_submit,
  input  logic              i_c1_instr_page,
  input  logic              i_c1_instr_long,
  input  logic [7:0]        i_c1_instr_addr_high,
  output logic [I_SIZE-1:0] o_c1_req_data,
  output logic              o_c1_req_data_valid,
  output logic              o_c1_fetch_err,
  output logic              o_mem_req,
  output logic [RW-1:0]     o_mem_addr,
  output logic [7:0]        o_mem_addr_high,
  output logic              o_mem_page,
  output logic              o_mem_long,
  input  logic [I_SIZE-1:0] i_mem_data,
  input  logic              i_mem_ack
);

  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen on the edge that ends the TIMEOUT-th cycle after grant.
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  fa_state_e     state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          mem_req_q, mem_req_d;
  logic [RW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_high_q, mem_high_d;
  logic          mem_page_q, mem_page_d;
  logic          mem_long_q, mem_long_d;

  logic [I_SIZE-1:0] data_q [2];
  logic [I_SIZE-1:0] data_d [2];
  logic [1:0]        vld_q, vld_d;
  logic [1:0]        err_q, err_d;

  logic [1:0]    slot_vld;
  logic [1:0]    slot_stale;
  logic [1:0]    slot_grant;
  logic [1:0]    slot_inflight;
  logic [RW-1:0] slot_addr [2];
  logic [7:0]    slot_high [2];
  logic [1:0]    slot_page;
  logic [1:0]    slot_long;

  logic ack;
  logic own_stale;
  logic pick;
  logic do_grant;
  logic tmo_hit;

  assign slot_inflight[0] = (state_q == FA_BUSY) && (owner_q == 1'b0);
  assign slot_inflight[1] = (state_q == FA_BUSY) && (owner_q == 1'b1);

  fetch_req_slot u_slot0 (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .submit_i    (i_c0_req_submit),
    .active_i    (i_c0_req_active),
    .addr_i      (i_c0_req_addr),
    .addr_high_i (i_c0_instr_addr_high),
    .page_i      (i_c0_instr_page),
    .long_i      (i_c0_instr_long),
    .grant_i     (slot_grant[0]),
    .inflight_i  (slot_inflight[0]),
    .req_vld_o   (slot_vld[0]),
    .addr_o      (slot_addr[0]),
    .addr_high_o (slot_high[0]),
    .page_o      (slot_page[0]),
    .long_o      (slot_long[0]),
    .stale_o     (slot_stale[0])
  );

  fetch_req_slot u_slot1 (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .submit_i    (i_c1_req_submit),
    .active_i    (i_c1_req_active),
    .addr_i      (i_c1_req_addr),
    .addr_high_i (i_c1_instr_addr_high),
    .page_i      (i_c1_instr_page),
    .long_i      (i_c1_instr_long),
    .grant_i     (slot_grant[1]),
    .inflight_i  (slot_inflight[1]),
    .req_vld_o   (slot_vld[1]),
    .addr_o      (slot_addr[1]),
    .addr_high_o (slot_high[1]),
    .page_o      (slot_page[1]),
    .long_o      (slot_long[1]),
    .stale_o     (slot_stale[1])
  );

  // The ack is only meaningful while a request is on the bus; this also makes
  // an ack after an asynchronous reset harmless.
  assign ack       = mem_req_q & i_mem_ack;
  assign own_stale = slot_stale[owner_q];
  assign pick      = rr_pick(slot_vld[0], slot_vld[1], last_q);
  assign tmo_hit   = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_high_d = mem_high_q;
    mem_page_d = mem_page_q;
    mem_long_d = mem_long_q;
    data_d[0]  = data_q[0];
    data_d[1]  = data_q[1];
    vld_d      = 2'b00;
    err_d      = 2'b00;
    slot_grant = 2'b00;
    do_grant   = 1'b0;

    case (state_q)
      FA_IDLE: begin
        do_grant = |slot_vld;
      end
      FA_BUSY: begin
        if (~&cnt_q) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (ack) begin
          if (!own_stale) begin
            data_d[owner_q] = i_mem_data;
            vld_d[owner_q]  = 1'b1;
          end
          // Re-grant on the ack edge so back-to-back fetches have no bubble.
          if (|slot_vld) begin
            do_grant = 1'b1;
          end else begin
            state_d   = FA_IDLE;
            mem_req_d = 1'b0;
          end
        end else if (tmo_hit) begin
          state_d   = FA_IDLE;
          mem_req_d = 1'b0;
          if (!own_stale) begin
            err_d[owner_q] = 1'b1;
          end
        end
      end
      default: begin
        state_d = FA_IDLE;
      end
    endcase

    if (do_grant) begin
      state_d          = FA_BUSY;
      owner_d          = pick;
      last_d           = pick;
      cnt_d            = '0;
      mem_req_d        = 1'b1;
      mem_addr_d       = slot_addr[pick];
      mem_high_d       = slot_high[pick];
      mem_page_d       = slot_page[pick];
      mem_long_d       = slot_long[pick];
      slot_grant[pick] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= FA_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_high_q <= '0;
      mem_page_q <= 1'b0;
      mem_long_q <= 1'b0;
      data_q[0]  <= '0;
      data_q[1]  <= '0;
      vld_q      <= 2'b00;
      err_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_high_q <= mem_high_d;
      mem_page_q <= mem_page_d;
      mem_long_q <= mem_long_d;
      data_q[0]  <= data_d[0];
      data_q[1]  <= data_d[1];
      vld_q      <= vld_d;
      err_q      <= err_d;
    end
  end

  assign o_mem_req           = mem_req_q;
  assign o_mem_addr          = mem_addr_q;
  assign o_mem_addr_high     = mem_high_q;
  assign o_mem_page          = mem_page_q;
  assign o_mem_long          = mem_long_q;
  assign o_c0_req_data       = data_q[0];
  assign o_c1_req_data       = data_q[1];
  assign o_c0_req_data_valid = vld_q[0];
  assign o_c1_req_data_valid = vld_q[1];
  assign o_c0_fetch_err      = err_q[0];
  assign o_c1_fetch_err      = err_q[1];

endmodule

// File: tb/tb_fetch_arbiter.sv
// Self-checking bench for fetch_arbiter: scenario tasks drive stimulus, push
// expected deliveries into a scoreboard queue and compare against a monitor.
module tb_fetch_arbiter;
  import fetch_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [RW-1:0]     c0_addr, c1_addr;
  logic              c0_active, c0_submit, c0_page, c0_long;
  logic              c1_active, c1_submit, c1_page, c1_long;
  logic [7:0]        c0_high, c1_high;
  logic [I_SIZE-1:0] o_c0_req_data, o_c1_req_data;
  logic              o_c0_req_data_valid, o_c1_req_data_valid;
  logic              o_c0_fetch_err, o_c1_fetch_err;
  logic              o_mem_req, o_mem_page, o_mem_long;
  logic [RW-1:0]     o_mem_addr;
  logic [7:0]        o_mem_addr_high;
  logic [I_SIZE-1:0] mem_data;
  logic              mem_ack;

  int tests = 0;
  int fails = 0;

  // {core, data}
  logic [I_SIZE:0] exp_q[$];
  logic [I_SIZE:0] obs_q[$];

  always #5 clk = ~clk;

  fetch_arbiter #(.TIMEOUT(8)) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_c0_req_addr        (c0_addr),
    .i_c0_req_active      (c0_active),
    .i_c0_req_submit      (c0_submit),
    .i_c0_instr_page      (c0_page),
    .i_c0_instr_long      (c0_long),
    .i_c0_instr_addr_high (c0_high),
    .o_c0_req_data        (o_c0_req_data),
    .o_c0_req_data_valid  (o_c0_req_data_valid),
    .o_c0_fetch_err       (o_c0_fetch_err),
    .i_c1_req_addr        (c1_addr),
    .i_c1_req_active      (c1_active),
    .i_c1_req_submit      (c1_submit),
    .i_c1_instr_page      (c1_page),
    .i_c1_instr_long      (c1_long),
    .i_c1_instr_addr_high (c1_high),
    .o_c1_req_data        (o_c1_req_data),
    .o_c1_req_data_valid  (o_c1_req_data_valid),
    .o_c1_fetch_err       (o_c1_fetch_err),
    .o_mem_req            (o_mem_req),
    .o_mem_addr           (o_mem_addr),
    .o_mem_addr_high      (o_mem_addr_high),
    .o_mem_page           (o_mem_page),
    .o_mem_long           (o_mem_long),
    .i_mem_data           (mem_data),
    .i_mem_ack            (mem_ack)
  );

  // Monitor: every valid pulse is recorded for the scoreboard.
  always @(negedge clk) begin
    if (o_c0_req_data_valid) obs_q.push_back({1'b0, o_c0_req_data});
    if (o_c1_req_data_valid) obs_q.push_back({1'b1, o_c1_req_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b, expected 0", o_mem_req); end
    tests++; if (o_mem_addr !== '0) begin fails++; $display("FAIL reset_mem_addr: got %h, expected 0", o_mem_addr); end
    tests++; if ({o_c0_req_data_valid, o_c1_req_data_valid} !== 2'b00) begin fails++; $display("FAIL reset_valid: got %b, expected 00", {o_c0_req_data_valid, o_c1_req_data_valid}); end
    tests++; if ({o_c0_fetch_err, o_c1_fetch_err} !== 2'b00) begin fails++; $display("FAIL reset_err: got %b, expected 00", {o_c0_fetch_err, o_c1_fetch_err}); end
    tests++; if (o_c0_req_data !== '0) begin fails++; $display("FAIL reset_data: got %h, expected 0", o_c0_req_data); end
    tick(); tick();
    rst = 1'b0;
    tick();
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL reset_idle: got %b, expected 0", o_mem_req); end
  endtask

  task automatic test_single();
    logic [I_SIZE:0] e, o;
    c0_addr = 16'h0040; c0_page = 1'b1; c0_long = 1'b0; c0_high = 8'hA5; c0_submit = 1'b1;
    tick();
    c0_submit = 1'b0;
    tests++; if (o_mem_req !== 1'b1) begin fails++; $display("FAIL single_req: got %b, expected 1", o_mem_req); end
    tests++; if (o_mem_addr !== 16'h0040) begin fails++; $display("FAIL single_addr: got %h, expected 0040", o_mem_addr); end
    tests++; if ({o_mem_addr_high, o_mem_page, o_mem_long} !== {8'hA5, 1'b1, 1'b0}) begin fails++; $display("FAIL single_attr: got %h/%b/%b, expected a5/1/0", o_mem_addr_high, o_mem_page, o_mem_long); end
    tick(); tick();
    mem_data = 32'hDEADBEEF; mem_ack = 1'b1;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    tick();
    mem_ack = 1'b0;
    tests++; if (o_c0_req_data_valid !== 1'b1 || o_c0_req_data !== 32'hDEADBEEF) begin fails++; $display("FAIL single_deliver: got %b/%h, expected 1/deadbeef", o_c0_req_data_valid, o_c0_req_data); end
    tests++; if (o_c1_req_data_valid !== 1'b0) begin fails++; $display("FAIL single_c1_quiet: got %b, expected 0", o_c1_req_data_valid); end
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL single_req_drop: got %b, expected 0", o_mem_req); end
    tick();
    tests++; if (o_c0_req_data_valid !== 1'b0 || o_c0_req_data !== 32'hDEADBEEF) begin fails++; $display("FAIL single_hold: got %b/%h, expected 0/deadbeef", o_c0_req_data_valid, o_c0_req_data); end
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL single_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL single_sb: got %h, expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_simultaneous();
    logic [I_SIZE:0] e, o;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    c0_addr = 16'h0010; c1_addr = 16'h0020; c0_submit = 1'b1; c1_submit = 1'b1;
    tick();
    c0_submit = 1'b0; c1_submit = 1'b0;
    tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0010) begin fails++; $display("FAIL tie_first: got %b/%h, expected 1/0010", o_mem_req, o_mem_addr); end
    tick();
    mem_data = 32'h11110000; mem_ack = 1'b1; exp_q.push_back({1'b0, 32'h11110000});
    tick();
    tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0020) begin fails++; $display("FAIL tie_no_bubble: got %b/%h, expected 1/0020", o_mem_req, o_mem_addr); end
    mem_data = 32'h22220000; exp_q.push_back({1'b1, 32'h22220000});
    tick();
    mem_ack = 1'b0;
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL tie_done: got %b, expected 0", o_mem_req); end
    c0_addr = 16'h0030; c1_addr = 16'h0050; c0_submit = 1'b1; c1_submit = 1'b1;
    tick();
    c0_submit = 1'b0; c1_submit = 1'b0;
    tests++; if (o_mem_addr !== 16'h0030) begin fails++; $display("FAIL tie_second: got %h, expected 0030", o_mem_addr); end
    mem_data = 32'h33330000; mem_ack = 1'b1; exp_q.push_back({1'b0, 32'h33330000});
    tick();
    tests++; if (o_mem_addr !== 16'h0050 || o_mem_req !== 1'b1) begin fails++; $display("FAIL tie_second_c1: got %b/%h, expected 1/0050", o_mem_req, o_mem_addr); end
    mem_data = 32'h55550000; exp_q.push_back({1'b1, 32'h55550000});
    tick();
    mem_ack = 1'b0;
    tick();
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL tie_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL tie_sb: got %h, expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_flush();
    logic [I_SIZE:0] e, o;
    c1_addr = 16'h0100; c1_submit = 1'b1;
    tick();
    c1_submit = 1'b0;
    tests++; if (o_mem_addr !== 16'h0100 || o_mem_req !== 1'b1) begin fails++; $display("FAIL flush_first: got %b/%h, expected 1/0100", o_mem_req, o_mem_addr); end
    tick();
    c1_addr = 16'h0200; c1_submit = 1'b1;
    tick();
    c1_submit = 1'b0;
    tests++; if (o_mem_addr !== 16'h0100) begin fails++; $display("FAIL flush_stable: got %h, expected 0100", o_mem_addr); end
    mem_data = 32'hBAD00100; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tests++; if (o_c1_req_data_valid !== 1'b0) begin fails++; $display("FAIL flush_drop: got %b, expected 0", o_c1_req_data_valid); end
    tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0200) begin fails++; $display("FAIL flush_reissue: got %b/%h, expected 1/0200", o_mem_req, o_mem_addr); end
    tick();
    mem_data = 32'h600D0200; mem_ack = 1'b1; exp_q.push_back({1'b1, 32'h600D0200});
    tick();
    mem_ack = 1'b0;
    tests++; if (o_c1_req_data_valid !== 1'b1 || o_c1_req_data !== 32'h600D0200) begin fails++; $display("FAIL flush_deliver: got %b/%h, expected 1/600d0200", o_c1_req_data_valid, o_c1_req_data); end
    tick();
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL flush_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL flush_sb: got %h, expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout();
    c0_addr = 16'h0400; c0_submit = 1'b1;
    tick();
    c0_submit = 1'b0;
    tests++; if (o_mem_req !== 1'b1) begin fails++; $display("FAIL tmo_grant: got %b, expected 1", o_mem_req); end
    for (int i = 0; i < 7; i++) tick();
    tests++; if (o_mem_req !== 1'b1 || o_c0_fetch_err !== 1'b0) begin fails++; $display("FAIL tmo_early: got req %b err %b, expected 1/0", o_mem_req, o_c0_fetch_err); end
    tick();
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL tmo_drop: got %b, expected 0", o_mem_req); end
    tests++; if (o_c0_fetch_err !== 1'b1 || o_c1_fetch_err !== 1'b0) begin fails++; $display("FAIL tmo_err: got %b%b, expected 10", o_c0_fetch_err, o_c1_fetch_err); end
    tick();
    tests++; if (o_c0_fetch_err !== 1'b0) begin fails++; $display("FAIL tmo_err_pulse: got %b, expected 0", o_c0_fetch_err); end
    mem_data = 32'h00000005; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tests++; if (o_c0_req_data_valid !== 1'b0) begin fails++; $display("FAIL tmo_late_ack: got %b, expected 0", o_c0_req_data_valid); end
    tick();
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL tmo_idle: got %b, expected 0", o_mem_req); end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL tmo_count: got %0d pulses, expected 0", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_disable();
    c0_addr = 16'h0300; c0_submit = 1'b1;
    tick();
    c0_submit = 1'b0;
    tests++; if (o_mem_addr !== 16'h0300 || o_mem_req !== 1'b1) begin fails++; $display("FAIL dis_grant: got %b/%h, expected 1/0300", o_mem_req, o_mem_addr); end
    c0_addr = 16'h0340; c0_submit = 1'b1;
    tick();
    c0_submit = 1'b0; c0_active = 1'b0;
    tick();
    c0_active = 1'b1;
    tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0300) begin fails++; $display("FAIL dis_inflight: got %b/%h, expected 1/0300", o_mem_req, o_mem_addr); end
    mem_data = 32'h00000077; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tests++; if (o_c0_req_data_valid !== 1'b0) begin fails++; $display("FAIL dis_no_valid: got %b, expected 0", o_c0_req_data_valid); end
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL dis_cleared: got %b, expected 0", o_mem_req); end
    tick();
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL dis_stay_idle: got %b, expected 0", o_mem_req); end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL dis_count: got %0d pulses, expected 0", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_async_reset();
    logic [I_SIZE:0] e, o;
    c1_addr = 16'h0500; c1_submit = 1'b1;
    tick();
    c1_submit = 1'b0;
    tests++; if (o_mem_req !== 1'b1) begin fails++; $display("FAIL arst_busy: got %b, expected 1", o_mem_req); end
    #3;
    rst = 1'b1;
    #1;
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL arst_drop: got %b, expected 0", o_mem_req); end
    tick();
    rst = 1'b0;
    mem_data = 32'h00000099; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tests++; if (o_c1_req_data_valid !== 1'b0 || o_mem_req !== 1'b0) begin fails++; $display("FAIL arst_no_stale: got valid %b req %b, expected 0/0", o_c1_req_data_valid, o_mem_req); end
    c0_addr = 16'h0600; c1_addr = 16'h0700; c0_submit = 1'b1; c1_submit = 1'b1;
    tick();
    c0_submit = 1'b0; c1_submit = 1'b0;
    tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0600) begin fails++; $display("FAIL arst_tie: got %b/%h, expected 1/0600", o_mem_req, o_mem_addr); end
    mem_data = 32'h0000000A; mem_ack = 1'b1; exp_q.push_back({1'b0, 32'h0000000A});
    tick();
    tests++; if (o_mem_addr !== 16'h0700) begin fails++; $display("FAIL arst_c1_next: got %h, expected 0700", o_mem_addr); end
    mem_data = 32'h0000000B; exp_q.push_back({1'b1, 32'h0000000B});
    tick();
    mem_ack = 1'b0;
    tick();
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL arst_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL arst_sb: got %h, expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    c0_addr = '0; c1_addr = '0; c0_high = '0; c1_high = '0;
    c0_active = 1'b1; c1_active = 1'b1;
    c0_submit = 1'b0; c1_submit = 1'b0;
    c0_page = 1'b0; c0_long = 1'b0; c1_page = 1'b0; c1_long = 1'b0;
    mem_data = '0; mem_ack = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_flush();
    test_timeout();
    test_disable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
